tt_gpio_cfg_ctrl: RTL and testbench
===================================

# tt_gpio_cfg_ctrl

Runtime configuration controller for the GPIO pad ring. It holds a shadow copy of every pad's configuration word and serially shifts the full image into the per-pad configuration chain, then strobes a load. This replaces the static per-pad CONFIG tie-offs with values that can be changed after boot. It sits between the top-level management interface and the chain of pad-side config latches feeding each `tt_gpio` instance.

## Interface
Parameters:
- `N_PADS`, 8: number of pads in the chain (≥1).
- `CFG_W`, 14: config word width. Bit 13 = analog path select, bits 12:11 = output wiring mode, bits 10:0 = pad tie-off bits in the same order as the GPIO CONFIG layout.
- `CLK_DIV`, 2: `ser_clk` half-period in `clk` cycles (≥1).
- `DEFAULT_CFG`, 14'h0000: reset value of every shadow entry.
- `BOOT_APPLY`, 1: if 1, an apply sequence runs automatically after reset.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write accepted when `wr_valid & wr_ready`.
- `wr_idx` input $clog2(N_PADS): pad index to write.
- `wr_cfg` input CFG_W: config word to write.
- `rd_idx` input $clog2(N_PADS): readback index.
- `rd_cfg` output CFG_W: shadow[rd_idx], combinational.
- `apply_valid` input 1: request to shift out the full shadow image.
- `apply_ready` output 1: apply accepted when `apply_valid & apply_ready`.
- `busy` output 1: apply sequence in progress.
- `done` output 1: one-cycle pulse when an apply completes.
- `ser_clk` output 1: chain shift clock.
- `ser_data` output 1: chain serial data.
- `ser_load` output 1: chain parallel-load strobe.

## Operation
- Shadow: N_PADS × CFG_W registers, reset to DEFAULT_CFG. A write updates `shadow[wr_idx]` at the accepting edge. An out-of-range `wr_idx` is accepted and discarded.
- `wr_ready = apply_ready = ~busy`. No writes are accepted during an apply, so the shifted image is consistent.
- A write and an apply accepted in the same cycle: the write is included in that apply.
- FSM states: IDLE → SETUP → RISE → (SETUP … ) → LOAD → IDLE.
  - SETUP: `ser_clk`=0; `ser_data` = current bit; held for CLK_DIV cycles.
  - RISE: `ser_clk`=1 and `ser_data` held for CLK_DIV cycles. If more bits remain, go to SETUP with the next bit; otherwise go to LOAD.
  - LOAD: `ser_clk`=0, `ser_load`=1 for CLK_DIV cycles, then go to IDLE.
  - `done`=1 in the first IDLE cycle after LOAD.
- Bit order: pad N_PADS-1 first, each word MSB first. The last bit shifted is pad 0 bit 0. Total bits = N_PADS*CFG_W.
- Counters: bit counter width $clog2(N_PADS*CFG_W+1); divider counter width $clog2(CLK_DIV+1). Both count down with no wrap; terminal value 0.
- `apply_valid` while busy is ignored; it is not queued.
- Boot: if BOOT_APPLY=1, the first cycle with `rst`=0 enters SETUP exactly as if an apply had been accepted in the last reset cycle.
- Reset at any point, including mid-shift: the FSM goes to IDLE, the shadow returns to DEFAULT_CFG, and the sequence is abandoned with no `ser_load`. The boot apply restarts after reset.

## Timing
- Reset values: `ser_clk`=0, `ser_data`=0, `ser_load`=0, `busy`=0, `done`=0. `wr_ready`/`apply_ready` follow `~busy`; inputs are ignored while `rst`=1.
- `busy`, `ser_*` and `done` are registered.
- Apply accepted at edge T:
  - `busy`=1 from cycle T+1.
  - `busy` drops to 0 in cycle T+1+(2*N_PADS*CFG_W+1)*CLK_DIV, with `done`=1 in that same cycle.
- `ser_data` changes only on `ser_clk` falling (SETUP entry), giving CLK_DIV cycles of setup and hold around each rising edge.

## Structure
- Shared header `tt_gpio_cfg_defs.vh`:
  - config field positions (ANA_SEL=13, OUT_MODE=12:11, tie-off bits 10:0) and CFG_W;
  - output-mode encodings (00 off/0, 01 off/1, 10 dynamic, 11 enabled);
  - FSM state encodings.
- One natural sub-module: `tt_gpio_cfg_tick`, the CLK_DIV down-counter producing a phase-end strobe, restartable by the FSM.
- The pad-side receive latch is a separate block and is out of scope here.

## Test plan
- Boot, N_PADS=2, CLK_DIV=1, DEFAULT_CFG=14'h2005:
  - `busy` rises the cycle after reset release;
  - 28 `ser_clk` pulses, captured stream = 2×14'h2005;
  - `ser_load` high 1 cycle;
  - `done` at cycle 57 after reset release.
- Write pad1=14'h3FFF, pad0=14'h0001, then apply: captured stream MSB-first = 3FFF then 0001, followed by one `ser_load`.
- Same-cycle write (pad1=14'h1234) and apply: the first 14 captured bits = 14'h1234.
- `wr_valid`/`apply_valid` held high while busy: `wr_ready`=0, shadow unchanged (checked via `rd_cfg`), no second apply after `done`.
- CLK_DIV=3: `ser_clk` high and low phases are 3 cycles each; `ser_data` is stable across each rising edge; the total apply length matches the formula.
- Assert `rst` mid-shift (bit 10): all `ser_*` = 0 the next cycle, no `ser_load`, shadow = DEFAULT_CFG, and a full boot apply restarts.

Source files
------------

// File: rtl/tt_gpio_cfg_pkg.sv
// Shared types for the GPIO pad configuration controller: config word layout,
// output-wiring mode encodings and serializer FSM states.
package tt_gpio_cfg_pkg;

   typedef enum logic [1:0] {
      OUT_OFF_LO  = 2'b00,
      OUT_OFF_HI  = 2'b01,
      OUT_DYNAMIC = 2'b10,
      OUT_ENABLED = 2'b11
   } out_mode_e;

   // Bit 13 analog select, bits 12:11 output mode, bits 10:0 pad tie-offs.
   typedef struct packed {
      logic       ana_sel;
      out_mode_e  out_mode;
      logic [10:0] tieoff;
   } cfg_word_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RISE  = 2'd2,
      ST_LOAD  = 2'd3
   } cfg_state_e;

endpackage

// File: rtl/tt_gpio_cfg_tick.sv
// Phase timer for the config serializer: strobes tick on the last cycle of every
// CLK_DIV-cycle phase; restart re-aligns the phase to the current edge.
module tt_gpio_cfg_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] ZERO   = CW'(0);

   logic [CW-1:0] cnt_r;

   assign tick = (cnt_r == ZERO);

   // Down-counter, reloaded at the end of each phase or on restart.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= RELOAD;
      end else if (restart || (cnt_r == ZERO)) begin
         cnt_r <= RELOAD;
      end else begin
         cnt_r <= cnt_r - ONE;
      end
   end

endmodule

// File: rtl/tt_gpio_cfg_ctrl.sv
// Runtime pad configuration controller: per-pad shadow registers plus a serializer
// that shifts the whole image into the pad config chain and strobes a load.
module tt_gpio_cfg_ctrl
   import tt_gpio_cfg_pkg::*;
#(
   parameter int               N_PADS      = 8,
   parameter int               CFG_W       = $bits(cfg_word_t),
   parameter int               CLK_DIV     = 2,
   parameter logic [CFG_W-1:0] DEFAULT_CFG = 14'h0000,
   parameter bit               BOOT_APPLY  = 1'b1,
   localparam int              IDX_W       = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [CFG_W-1:0] wr_cfg,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CFG_W-1:0] rd_cfg,
   input  logic             apply_valid,
   output logic             apply_ready,
   output logic             busy,
   output logic             done,
   output logic             ser_clk,
   output logic             ser_data,
   output logic             ser_load
);

   localparam int TOTAL = N_PADS * CFG_W;
   localparam int BIT_W = $clog2(TOTAL + 1);
   localparam logic [IDX_W:0]   N_PADS_L  = (IDX_W + 1)'(N_PADS);
   localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(TOTAL - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);

   cfg_state_e       state_r, state_nxt_s;
   logic [BIT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
   logic [CFG_W-1:0] shadow_r     [N_PADS];
   logic [CFG_W-1:0] shadow_nxt_s [N_PADS];
   logic [TOTAL-1:0] image_s;
   logic             wr_fire_s, start_s, tick_s, restart_s;
   logic             busy_r, busy_nxt_s, done_r, done_nxt_s, boot_r;
   logic             ser_clk_r, ser_clk_nxt_s, ser_data_r, ser_data_nxt_s;
   logic             ser_load_r, ser_load_nxt_s;

   assign wr_ready    = ~busy_r;
   assign apply_ready = ~busy_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign ser_clk     = ser_clk_r;
   assign ser_data    = ser_data_r;
   assign ser_load    = ser_load_r;

   assign wr_fire_s = wr_valid & ~busy_r & ({1'b0, wr_idx} < N_PADS_L);
   assign start_s   = ~busy_r & (apply_valid | boot_r);

   // Post-write shadow view, so a write accepted with an apply lands in that image.
   always_comb begin
      for (int i = 0; i < N_PADS; i++) begin
         shadow_nxt_s[i] = (wr_fire_s && (IDX_W'(i) == wr_idx)) ? wr_cfg : shadow_r[i];
      end
   end

   // Flattened image: pad N_PADS-1 occupies the top bits, so shifting goes top-down.
   always_comb begin
      image_s = {TOTAL{1'b0}};
      for (int i = 0; i < N_PADS; i++) begin
         image_s[i*CFG_W +: CFG_W] = shadow_nxt_s[i];
      end
   end

   // Readback mux; unused index codes read as zero.
   always_comb begin
      if ({1'b0, rd_idx} < N_PADS_L) begin
         rd_cfg = shadow_r[rd_idx];
      end else begin
         rd_cfg = {CFG_W{1'b0}};
      end
   end

   // Shadow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_PADS; i++) begin
            shadow_r[i] <= DEFAULT_CFG;
         end
      end else begin
         for (int i = 0; i < N_PADS; i++) begin
            shadow_r[i] <= shadow_nxt_s[i];
         end
      end
   end

   tt_gpio_cfg_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart_s),
      .tick    (tick_s)
   );

   // Serializer next-state and output logic.
   always_comb begin
      state_nxt_s    = state_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      busy_nxt_s     = busy_r;
      done_nxt_s     = 1'b0;
      ser_clk_nxt_s  = ser_clk_r;
      ser_data_nxt_s = ser_data_r;
      ser_load_nxt_s = ser_load_r;
      restart_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s    = ST_SETUP;
               bit_cnt_nxt_s  = BIT_FIRST;
               ser_data_nxt_s = image_s[TOTAL-1];
               ser_clk_nxt_s  = 1'b0;
               busy_nxt_s     = 1'b1;
               restart_s      = 1'b1;
            end else begin
               busy_nxt_s     = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick_s) begin
               state_nxt_s   = ST_RISE;
               ser_clk_nxt_s = 1'b1;
            end else begin
               state_nxt_s   = ST_SETUP;
            end
         end
         ST_RISE: begin
            if (tick_s) begin
               ser_clk_nxt_s = 1'b0;
               // bit_cnt_r counts the bits still to go after the one on the wire.
               if (bit_cnt_r != BIT_ZERO) begin
                  state_nxt_s    = ST_SETUP;
                  bit_cnt_nxt_s  = bit_cnt_r - BIT_ONE;
                  ser_data_nxt_s = image_s[bit_cnt_r - BIT_ONE];
               end else begin
                  state_nxt_s    = ST_LOAD;
                  ser_load_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_RISE;
            end
         end
         ST_LOAD: begin
            if (tick_s) begin
               state_nxt_s    = ST_IDLE;
               ser_load_nxt_s = 1'b0;
               busy_nxt_s     = 1'b0;
               done_nxt_s     = 1'b1;
            end else begin
               state_nxt_s    = ST_LOAD;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            ser_clk_nxt_s  = 1'b0;
            ser_load_nxt_s = 1'b0;
            busy_nxt_s     = 1'b0;
         end
      endcase
   end

   // Serializer state and registered outputs; reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= BIT_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ser_clk_r  <= 1'b0;
         ser_data_r <= 1'b0;
         ser_load_r <= 1'b0;
         boot_r     <= BOOT_APPLY;
      end else begin
         state_r    <= state_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         ser_clk_r  <= ser_clk_nxt_s;
         ser_data_r <= ser_data_nxt_s;
         ser_load_r <= ser_load_nxt_s;
         boot_r     <= boot_r & ~start_s;
      end
   end

endmodule

// File: tb/tb_tt_gpio_cfg_ctrl.sv
// Directed + randomized bench for tt_gpio_cfg_ctrl: captures the serial chain on
// ser_clk rising edges and compares it against a shadow-array model.
module tb_tt_gpio_cfg_ctrl;

   localparam int N       = 3;
   localparam int W       = 14;
   localparam int D       = 3;
   localparam logic [13:0] DEF = 14'h2005;
   localparam int TOTAL     = N * W;
   localparam int APPLY_LEN = (2 * TOTAL + 1) * D;
   localparam int LIMIT     = 4 * APPLY_LEN;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0, apply_valid = 1'b0;
   logic [1:0]  wr_idx = 2'd0, rd_idx = 2'd0;
   logic [13:0] wr_cfg = 14'h0;
   logic        wr_ready, apply_ready, busy, done, ser_clk, ser_data, ser_load;
   logic [13:0] rd_cfg;

   int total = 0;
   int bad   = 0;

   logic [13:0] m_shadow [N];
   logic        cap_q [$];
   int          load_pulses, load_cycles, high_run, low_run;
   logic        prev_clk = 1'b0, prev_data = 1'b0, prev_load = 1'b0;

   tt_gpio_cfg_ctrl #(
      .N_PADS(N), .CFG_W(W), .CLK_DIV(D), .DEFAULT_CFG(DEF), .BOOT_APPLY(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_cfg(wr_cfg), .rd_idx(rd_idx), .rd_cfg(rd_cfg),
      .apply_valid(apply_valid), .apply_ready(apply_ready), .busy(busy),
      .done(done), .ser_clk(ser_clk), .ser_data(ser_data), .ser_load(ser_load)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then sample and watch the serial chain like a pad-side latch would.
   task automatic step();
      @(posedge clk);
      #1;
      if (ser_clk) begin
         if (!prev_clk) begin
            cap_q.push_back(ser_data);
            chk("setup_len", low_run, D);
         end
         chk("data_hold", ser_data, prev_data);
         high_run++;
         low_run = 0;
      end else begin
         if (prev_clk && busy) chk("high_len", high_run, D);
         high_run = 0;
         if (busy && !ser_load) low_run++;
         else low_run = 0;
      end
      if (ser_load) begin
         load_cycles++;
         if (!prev_load) begin
            load_pulses++;
            chk("load_after_all_bits", cap_q.size(), TOTAL);
         end
      end
      prev_clk  = ser_clk;
      prev_data = ser_data;
      prev_load = ser_load;
   endtask

   task automatic clear_capture();
      cap_q.delete();
      load_pulses = 0;
      load_cycles = 0;
   endtask

   task automatic do_write(input logic [1:0] idx, input logic [13:0] d);
      wr_valid = 1'b1; wr_idx = idx; wr_cfg = d;
      step();
      wr_valid = 1'b0;
      if (idx < N) m_shadow[idx] = d;
   endtask

   task automatic check_shadow(input string tag);
      for (int i = 0; i < N; i++) begin
         rd_idx = 2'(i);
         #1;
         chk(tag, rd_cfg, m_shadow[i]);
      end
   endtask

   // n0 = clocks already elapsed since the accepting edge.
   task automatic wait_done(input int n0, input string tag);
      int n = n0;
      while (done !== 1'b1 && n < LIMIT) begin
         step();
         n++;
      end
      chk({tag, "_len"}, n, APPLY_LEN);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
   endtask

   task automatic check_stream(input string tag);
      logic [63:0] exp_v = 64'h0;
      logic [63:0] got_v = 64'h0;
      for (int p = N - 1; p >= 0; p--)
         for (int b = W - 1; b >= 0; b--)
            exp_v = {exp_v[62:0], m_shadow[p][b]};
      foreach (cap_q[k]) got_v = {got_v[62:0], cap_q[k]};
      chk({tag, "_nbits"}, cap_q.size(), TOTAL);
      chk({tag, "_stream"}, got_v, exp_v);
      chk({tag, "_load_pulses"}, load_pulses, 1);
      chk({tag, "_load_cycles"}, load_cycles, D);
   endtask

   task automatic start_apply();
      clear_capture();
      apply_valid = 1'b1;
      step();
      apply_valid = 1'b0;
      chk("apply_busy", busy, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_shadow[i] = DEF;
      clear_capture();
      high_run = 0;
      low_run  = 0;

      // Reset state
      repeat (3) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ser", {ser_clk, ser_data, ser_load}, 3'b000);
      chk("rst_ready", {wr_ready, apply_ready}, 2'b11);
      check_shadow("rst_shadow");

      // Boot apply of the default image
      rst = 1'b0;
      step();
      chk("boot_busy", busy, 1'b1);
      wait_done(0, "boot");
      check_stream("boot");
      step();
      chk("boot_done_pulse", done, 1'b0);

      // Directed and random writes, including an out-of-range index
      do_write(2'd1, 14'h3FFF);
      do_write(2'd0, 14'h0001);
      do_write(2'd3, 14'h1ABC);
      check_shadow("wr_directed");
      start_apply();
      wait_done(0, "apply1");
      check_stream("apply1");
      for (int k = 0; k < 6; k++) do_write(2'($urandom_range(0, 3)), 14'($urandom));
      check_shadow("wr_random");
      start_apply();
      wait_done(0, "apply2");
      check_stream("apply2");

      // Write and apply accepted on the same edge
      clear_capture();
      wr_valid = 1'b1; wr_idx = 2'd2; wr_cfg = 14'($urandom);
      apply_valid = 1'b1;
      step();
      m_shadow[2] = wr_cfg;
      wr_valid = 1'b0; apply_valid = 1'b0;
      chk("same_cycle_busy", busy, 1'b1);
      wait_done(0, "same_cycle");
      check_stream("same_cycle");

      // Requests held high while busy are refused and not queued
      start_apply();
      apply_valid = 1'b1;
      wr_valid = 1'b1; wr_idx = 2'd0; wr_cfg = ~m_shadow[0];
      step();
      step();
      chk("held_wr_ready", wr_ready, 1'b0);
      chk("held_apply_ready", apply_ready, 1'b0);
      wait_done(2, "held");
      apply_valid = 1'b0;
      wr_valid = 1'b0;
      check_stream("held");
      check_shadow("held_shadow");
      step();
      chk("held_no_reapply", busy, 1'b0);
      step();
      chk("held_idle", busy, 1'b0);

      // Reset during the shift of bit 10
      do_write(2'd1, 14'($urandom));
      start_apply();
      for (int c = 0; c < LIMIT && cap_q.size() < 10; c++) step();
      chk("mid_bits", cap_q.size(), 10);
      rst = 1'b1;
      step();
      chk("mid_rst_ser", {ser_clk, ser_data, ser_load}, 3'b000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_noload", load_pulses, 0);
      step();
      for (int i = 0; i < N; i++) m_shadow[i] = DEF;
      check_shadow("mid_rst_shadow");
      clear_capture();
      rst = 1'b0;
      step();
      chk("reboot_busy", busy, 1'b1);
      wait_done(0, "reboot");
      check_stream("reboot");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
